// File: rtl/sfp_link_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sfp_link_ctrl
//
// Per-cage SFP management sequencer. Conditions the raw cage status pins
// (2-flop synchroniser + debouncer), holds the laser off for a settle time
// after insertion, and applies a bounded retry / lockout policy on TX_FAULT.
//
// Ports
//   clkusr_100m    in   100 MHz user clock, all logic on rising edge
//   nreset         in   synchronous active-low reset
//   sfp_mod_abs    in   raw cage pin, 1 = no module
//   sfp_rxlos      in   raw cage pin, 1 = loss of signal
//   sfp_tx_fault   in   raw cage pin, 1 = transmitter fault
//   sfp_tx_dis     out  registered, 1 = laser disabled
//   sfp_rs0/rs1    out  constant 1 (full-rate select)
//   mod_present    out  debounced, inverted MOD_ABS
//   link_ok        out  ACTIVE and debounced RX_LOS low
//   fault_latched  out  high while locked out after repeated faults
//   retry_cnt      out  faults seen since the last insertion (saturating)
//   led            out  1 = lit (board polarity handled above this block)
// -----------------------------------------------------------------------------
module sfp_link_ctrl #(
    parameter int DEBOUNCE_CYC    = 1_000_000,
    parameter int INSERT_DLY_CYC  = 30_000_000,
    parameter int FAULT_RETRY_CYC = 10_000_000,
    parameter int BLINK_CYC       = 25_000_000,
    parameter int MAX_RETRY       = 3
) (
    input  logic       clkusr_100m,
    input  logic       nreset,
    input  logic       sfp_mod_abs,
    input  logic       sfp_rxlos,
    input  logic       sfp_tx_fault,
    output logic       sfp_tx_dis,
    output logic       sfp_rs0,
    output logic       sfp_rs1,
    output logic       mod_present,
    output logic       link_ok,
    output logic       fault_latched,
    output logic [1:0] retry_cnt,
    output logic       led
);

    // One timer serves both the settle and the fault-hold intervals.
    localparam int TMR_SPAN = (INSERT_DLY_CYC > FAULT_RETRY_CYC) ? INSERT_DLY_CYC : FAULT_RETRY_CYC;
    localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_W    = $clog2(TMR_SPAN + 1);
    localparam int BLK_W    = $clog2(BLINK_CYC + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_ZERO   = DB_W'(0);
    localparam logic [TMR_W-1:0] INS_LAST  = TMR_W'(INSERT_DLY_CYC - 1);
    localparam logic [TMR_W-1:0] RET_LAST  = TMR_W'(FAULT_RETRY_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_CYC - 1);
    localparam logic [BLK_W-1:0] BLK_ONE   = BLK_W'(1);
    localparam logic [BLK_W-1:0] BLK_ZERO  = BLK_W'(0);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [1:0]       RETRY_ONE = 2'b01;

    // Bit positions of the three conditioned pins.
    localparam int IDX_ABS = 0;
    localparam int IDX_LOS = 1;
    localparam int IDX_FLT = 2;
    // Safe idle values: module absent, no signal, no fault.
    localparam logic [2:0] PIN_IDLE = 3'b011;

    typedef enum logic [2:0] {
        ST_ABSENT     = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_ACTIVE     = 3'd2,
        ST_FAULT_WAIT = 3'd3,
        ST_LOCKOUT    = 3'd4
    } state_t;

    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      deb_r;
    logic [2:0]      deb_nxt_s;
    logic [DB_W-1:0] deb_cnt_r     [3];
    logic [DB_W-1:0] deb_cnt_nxt_s [3];

    logic [BLK_W-1:0] blink_cnt_r;
    logic [BLK_W-1:0] blink_cnt_nxt_s;
    logic             blink_r;
    logic             blink_nxt_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic [1:0]       retry_r;
    logic [1:0]       retry_nxt_s;
    logic             mod_present_r;
    logic             tx_dis_r;
    logic             link_ok_r;
    logic             fault_latched_r;
    logic             led_r;
    logic             link_nxt_s;
    logic             led_nxt_s;

    assign raw_s = {sfp_tx_fault, sfp_rxlos, sfp_mod_abs};

    // Debounce next-state: accept the synchronised level only after it has
    // differed from the accepted level for DEBOUNCE_CYC consecutive cycles.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_nxt_s[i]     = deb_r[i];
            deb_cnt_nxt_s[i] = DB_ZERO;
            if (sync2_r[i] != deb_r[i]) begin
                if (deb_cnt_r[i] == DB_LAST) begin
                    deb_nxt_s[i] = sync2_r[i];
                end else begin
                    deb_cnt_nxt_s[i] = deb_cnt_r[i] + DB_ONE;
                end
            end else begin
                deb_cnt_nxt_s[i] = DB_ZERO;
            end
        end
    end

    // Synchroniser flops and debounce state for the three cage pins.
    always_ff @(posedge clkusr_100m) begin
        if (!nreset) begin
            sync1_r <= PIN_IDLE;
            sync2_r <= PIN_IDLE;
            deb_r   <= PIN_IDLE;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= DB_ZERO;
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_r   <= deb_nxt_s;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= deb_cnt_nxt_s[i];
            end
        end
    end

    // Free-running blink phase: toggles once every BLINK_CYC cycles.
    always_comb begin
        blink_nxt_s = blink_r;
        if (blink_cnt_r == BLK_LAST) begin
            blink_cnt_nxt_s = BLK_ZERO;
            blink_nxt_s     = ~blink_r;
        end else begin
            blink_cnt_nxt_s = blink_cnt_r + BLK_ONE;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clkusr_100m) begin
        if (!nreset) begin
            blink_cnt_r <= BLK_ZERO;
            blink_r     <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_r     <= blink_nxt_s;
        end
    end

    // Sequencer next-state. Removal overrides everything; the timer is cleared
    // by default so every state entry starts it from zero.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = TMR_ZERO;
        retry_nxt_s = retry_r;
        if (!mod_present_r) begin
            state_nxt_s = ST_ABSENT;
            retry_nxt_s = 2'b00;
        end else begin
            case (state_r)
                ST_ABSENT: begin
                    state_nxt_s = ST_SETTLE;
                    retry_nxt_s = 2'b00;
                end
                ST_SETTLE: begin
                    if (timer_r == INS_LAST) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        timer_nxt_s = timer_r + TMR_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (deb_r[IDX_FLT]) begin
                        state_nxt_s = ST_FAULT_WAIT;
                        if (retry_r == RETRY_MAX) begin
                            retry_nxt_s = retry_r;
                        end else begin
                            retry_nxt_s = retry_r + RETRY_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end
                ST_FAULT_WAIT: begin
                    if (timer_r == RET_LAST) begin
                        if (retry_r == RETRY_MAX) begin
                            state_nxt_s = ST_LOCKOUT;
                        end else begin
                            state_nxt_s = ST_ACTIVE;
                        end
                    end else begin
                        timer_nxt_s = timer_r + TMR_ONE;
                    end
                end
                ST_LOCKOUT: begin
                    state_nxt_s = ST_LOCKOUT;
                end
                default: begin
                    state_nxt_s = ST_ABSENT;
                    retry_nxt_s = 2'b00;
                end
            endcase
        end

        // Outputs are decoded from next-state values so that the registered
        // copies change on the same edge as the state register itself.
        link_nxt_s = (state_nxt_s == ST_ACTIVE) && !deb_nxt_s[IDX_LOS];
        case (state_nxt_s)
            ST_ABSENT:     led_nxt_s = 1'b0;
            ST_ACTIVE:     led_nxt_s = link_nxt_s;
            ST_SETTLE,
            ST_FAULT_WAIT,
            ST_LOCKOUT:    led_nxt_s = blink_nxt_s;
            default:       led_nxt_s = 1'b0;
        endcase
    end

    // Sequencer state register and all registered status outputs.
    always_ff @(posedge clkusr_100m) begin
        if (!nreset) begin
            state_r         <= ST_ABSENT;
            timer_r         <= TMR_ZERO;
            retry_r         <= 2'b00;
            mod_present_r   <= 1'b0;
            tx_dis_r        <= 1'b1;
            link_ok_r       <= 1'b0;
            fault_latched_r <= 1'b0;
            led_r           <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            timer_r         <= timer_nxt_s;
            retry_r         <= retry_nxt_s;
            mod_present_r   <= ~deb_nxt_s[IDX_ABS];
            tx_dis_r        <= (state_nxt_s != ST_ACTIVE);
            link_ok_r       <= link_nxt_s;
            fault_latched_r <= (state_nxt_s == ST_LOCKOUT);
            led_r           <= led_nxt_s;
        end
    end

    assign sfp_tx_dis    = tx_dis_r;
    assign sfp_rs0       = 1'b1;
    assign sfp_rs1       = 1'b1;
    assign mod_present   = mod_present_r;
    assign link_ok       = link_ok_r;
    assign fault_latched = fault_latched_r;
    assign retry_cnt     = retry_r;
    assign led           = led_r;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sfp_link_ctrl
//
// Directed bench for sfp_link_ctrl with short timing parameters. The stimulus
// process queues expected output vectors tagged with the absolute clock cycle
// at which they must hold; a monitor process counts cycles and compares every
// queued entry that falls due.
//
// Output vector layout: {rs1, rs0, tx_dis, mod_present, link_ok,
//                        fault_latched, retry_cnt[1:0], led}
// Cycle m below is counted in rising edges after the latest reset release.
// -----------------------------------------------------------------------------
module tb_sfp_link_ctrl;

  localparam int DEB   = 4;
  localparam int INS   = 20;
  localparam int RET   = 10;
  localparam int BLINK = 3;
  localparam int MAXR  = 3;

  logic       clk = 1'b0;
  logic       nreset;
  logic       mod_abs;
  logic       rxlos;
  logic       tx_fault;
  logic       tx_dis;
  logic       rs0;
  logic       rs1;
  logic       mod_present;
  logic       link_ok;
  logic       fault_latched;
  logic [1:0] retry_cnt;
  logic       led;

  typedef struct {
    int         cyc;
    string      name;
    logic [8:0] mask;
    logic [8:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   base  = 0;
  int   total = 0;
  int   bad   = 0;

  sfp_link_ctrl #(
    .DEBOUNCE_CYC    (DEB),
    .INSERT_DLY_CYC  (INS),
    .FAULT_RETRY_CYC (RET),
    .BLINK_CYC       (BLINK),
    .MAX_RETRY       (MAXR)
  ) dut (
    .clkusr_100m   (clk),
    .nreset        (nreset),
    .sfp_mod_abs   (mod_abs),
    .sfp_rxlos     (rxlos),
    .sfp_tx_fault  (tx_fault),
    .sfp_tx_dis    (tx_dis),
    .sfp_rs0       (rs0),
    .sfp_rs1       (rs1),
    .mod_present   (mod_present),
    .link_ok       (link_ok),
    .fault_latched (fault_latched),
    .retry_cnt     (retry_cnt),
    .led           (led)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ov(logic td, logic mp, logic lk, logic fl,
                                    logic [1:0] rc, logic ld);
    return {1'b1, 1'b1, td, mp, lk, fl, rc, ld};
  endfunction

  // LED level in a blinking state after m edges since reset release:
  // the phase flips after every BLINK edges, starting from 0.
  function automatic logic blink_at(int m);
    int q;
    q = m / BLINK;
    return ((q % 2) == 1);
  endfunction

  task automatic chk(input int m, input string nm, input logic [8:0] v);
    exp_t e;
    e.cyc  = base + m;
    e.name = nm;
    e.mask = 9'h1FF;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk_tx(input int m, input string nm, input logic td);
    exp_t e;
    e.cyc  = base + m;
    e.name = nm;
    e.mask = 9'b001000000;
    e.val  = {2'b00, td, 6'b000000};
    exp_q.push_back(e);
  endtask

  // Return at the falling edge that follows rising edge number base+m.
  task automatic wait_rel(input int m);
    while (cyc < base + m) @(negedge clk);
  endtask

  // Monitor: count edges, compare every expectation that falls due.
  initial begin
    logic [8:0] obs;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      obs = {rs1, rs0, tx_dis, mod_present, link_ok, fault_latched, retry_cnt, led};
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          total = total + 1;
          if (exp_q[i].cyc < cyc) begin
            bad = bad + 1;
            $display("FAIL %s: due at cycle %0d, not evaluated (now %0d)",
                     exp_q[i].name, exp_q[i].cyc, cyc);
          end else if ((obs & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
            bad = bad + 1;
            $display("FAIL %s @cycle %0d: got %b, expected %b (mask %b)",
                     exp_q[i].name, cyc, obs, exp_q[i].val, exp_q[i].mask);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    nreset   = 1'b0;
    mod_abs  = 1'b0;
    rxlos    = 1'b0;
    tx_fault = 1'b0;
    base     = 4;

    // Power-up with module inserted, no LOS.
    chk(0,  "reset_values",    ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(5,  "pre_debounce",    ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(6,  "mod_present_c6",  ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(7,  "settle_entry",    ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(7)));
    chk(9,  "settle_blink",    ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(9)));
    chk(26, "settle_last",     ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(26)));
    chk(27, "tx_enable_c27",   ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    wait_rel(0);
    nreset = 1'b1;

    // 3-cycle glitches on all three pins while ACTIVE.
    chk(33, "glitch_mid",      ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(36, "glitch_after",    ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(38, "glitch_settled",  ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    wait_rel(30);
    mod_abs = 1'b1; rxlos = 1'b1; tx_fault = 1'b1;
    wait_rel(33);
    mod_abs = 1'b0; rxlos = 1'b0; tx_fault = 1'b0;

    // Persistent fault: three 10-cycle pulses, then lockout.
    chk(46, "fault_pre",       ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(47, "fault1_start",    ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, blink_at(47)));
    chk(56, "fault1_end",      ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, blink_at(56)));
    chk(57, "retry1_active",   ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1));
    chk(58, "fault2_start",    ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, blink_at(58)));
    chk(67, "fault2_end",      ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, blink_at(67)));
    chk(68, "retry2_active",   ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1));
    chk(69, "fault3_start",    ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, blink_at(69)));
    chk(78, "fault3_end",      ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, blink_at(78)));
    for (int m = 79; m <= 95; m++) begin
      chk(m, "lockout_blink",  ov(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, blink_at(m)));
    end
    wait_rel(40);
    tx_fault = 1'b1;

    // Removal from lockout for 6 cycles, then re-insertion.
    chk(96,  "lockout_remove", ov(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, blink_at(96)));
    chk(97,  "absent_clear",   ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(101, "absent_hold",    ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(102, "reinsert_deb",   ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(103, "reinsert_settle",ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(103)));
    chk(122, "reinsert_last",  ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(122)));
    chk(123, "reinsert_en",    ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    wait_rel(90);
    mod_abs = 1'b1; tx_fault = 1'b0;
    wait_rel(96);
    mod_abs = 1'b0;

    // Removal from ACTIVE, re-insertion, then removal one cycle before expiry.
    chk(131, "remove_seen",    ov(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(132, "remove_absent",  ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(141, "insert2_deb",    ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(142, "insert2_settle", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(142)));
    chk(160, "settle_c18",     ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(160)));
    chk(161, "settle_c19_rm",  ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, blink_at(161)));
    chk(162, "rm_beats_expiry",ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(165, "rm_absent",      ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    for (int m = 132; m <= 196; m++) begin
      chk_tx(m, "tx_dis_held", 1'b1);
    end
    wait_rel(125);
    mod_abs = 1'b1;
    wait_rel(135);
    mod_abs = 1'b0;
    wait_rel(155);
    mod_abs = 1'b1;

    // Re-insert and toggle RX_LOS with 10-cycle holds while ACTIVE.
    chk(197, "insert3_en",     ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(205, "los1_pre",       ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(206, "los1_seen",      ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(215, "los1_hold",      ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(216, "los1_clear",     ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(225, "los2_pre",       ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(226, "los2_seen",      ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(236, "los2_clear",     ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    chk(245, "pre_reset",      ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    for (int m = 197; m <= 245; m++) begin
      chk_tx(m, "tx_on_during_los", 1'b0);
    end
    wait_rel(170);
    mod_abs = 1'b0;
    wait_rel(200);
    rxlos = 1'b1;
    wait_rel(210);
    rxlos = 1'b0;
    wait_rel(220);
    rxlos = 1'b1;
    wait_rel(230);
    rxlos = 1'b0;

    // Reset while ACTIVE: laser off on the reset edge, full sequence after.
    wait_rel(245);
    chk(246, "reset_in_active", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    nreset = 1'b0;
    wait_rel(247);
    base = base + 247;
    chk(5,  "rst2_pre_deb",    ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(6,  "rst2_present",    ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    chk(26, "rst2_settle_end", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, blink_at(26)));
    chk(27, "rst2_tx_enable",  ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    nreset = 1'b1;
    wait_rel(32);

    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL pending_checks: %0d left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
